// File: rtl/card_pick_adder_pkg.sv
// card_pkg: FSM/command encodings and row/column index helpers shared by card_pick_adder.
package card_pkg;

   typedef enum logic [1:0] {IDLE, PICKED, RESULT} state_t;

   typedef enum logic [2:0] {
      CMD_NONE, CMD_CANCEL, CMD_UP, CMD_DOWN, CMD_LEFT, CMD_RIGHT, CMD_OK
   } cmd_t;

   function automatic int idx(input int row, input int col, input int num_max);
      return row * num_max + col;
   endfunction

   function automatic int row_of(input int index, input int num_max);
      return (index >= num_max) ? 1 : 0;
   endfunction

   function automatic int col_of(input int index, input int num_max);
      return (index >= num_max) ? index - num_max : index;
   endfunction

   // A row count of 0 still leaves one usable card; oversize counts saturate.
   function automatic int eff_num(input int num, input int num_max);
      if (num == 0) return 1;
      if (num > num_max) return num_max;
      return num;
   endfunction

endpackage

// File: rtl/card_pick_adder_btn_edge.sv
// btn_edge: rising-edge detector for one debounced button level.
module btn_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic i_btn,
   output logic o_rise
);

   logic r_prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_prev <= 1'b0;
      else        r_prev <= i_btn;
   end

   assign o_rise = i_btn & ~r_prev;

endmodule

// File: rtl/card_pick_adder.sv
// card_pick_adder: two-row card cursor, two-pick FSM and modular adder with sticky draw flags.
// Optional `define CARD_PICK_CANCEL_EN adds a btn_cancel input that aborts a pending pick.
module card_pick_adder
   import card_pkg::*;
#(
   parameter int NUM_MAX = 5,
   parameter int DIGIT_W = 4,
   parameter int MODULUS = 10,
   parameter int IDX_W   = $clog2(2*NUM_MAX),
   parameter int NUM_W   = $clog2(NUM_MAX+1)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         player,
   input  logic [NUM_W-1:0]             num,
   input  logic [2*NUM_MAX*DIGIT_W-1:0] status,
   input  logic                         btn_up,
   input  logic                         btn_down,
   input  logic                         btn_left,
   input  logic                         btn_right,
   input  logic                         btn_ok,
`ifdef CARD_PICK_CANCEL_EN
   input  logic                         btn_cancel,
`endif
   input  logic                         clr_draw,
   output logic [IDX_W-1:0]             cursor,
   output logic                         picked,
   output logic [IDX_W-1:0]             sel_index,
   output logic                         res_valid,
   output logic [DIGIT_W-1:0]           res_value,
   output logic [IDX_W-1:0]             res_dst,
   output logic [IDX_W-1:0]             res_src,
   output logic                         rej,
   output logic                         draw1,
   output logic                         draw2
);

   logic w_up, w_down, w_left, w_right, w_ok, w_cancel;

   btn_edge u_edge_up    (.clk, .rst_n, .i_btn(btn_up),    .o_rise(w_up));
   btn_edge u_edge_down  (.clk, .rst_n, .i_btn(btn_down),  .o_rise(w_down));
   btn_edge u_edge_left  (.clk, .rst_n, .i_btn(btn_left),  .o_rise(w_left));
   btn_edge u_edge_right (.clk, .rst_n, .i_btn(btn_right), .o_rise(w_right));
   btn_edge u_edge_ok    (.clk, .rst_n, .i_btn(btn_ok),    .o_rise(w_ok));
`ifdef CARD_PICK_CANCEL_EN
   btn_edge u_edge_cancel(.clk, .rst_n, .i_btn(btn_cancel), .o_rise(w_cancel));
`else
   assign w_cancel = 1'b0;
`endif

   state_t             r_state, w_state_nx;
   cmd_t               w_cmd;
   logic [IDX_W-1:0]   r_cursor, w_cursor_nx, r_sel_index, r_res_dst, r_res_src;
   logic [DIGIT_W-1:0] r_a, r_res_value, w_card, w_res_value;
   logic [DIGIT_W:0]   w_sum;
   logic               r_res_valid, r_rej, r_draw1, r_draw2;
   logic               w_rej, w_pick, w_result, w_cursor_zero;
   logic               w_row, w_sel_row, w_zero_pick;
   int                 w_n, w_col;

   assign w_n       = eff_num(int'(num), NUM_MAX);
   assign w_row     = (row_of(int'(r_cursor), NUM_MAX) == 1);
   assign w_col     = col_of(int'(r_cursor), NUM_MAX);
   assign w_sel_row = (row_of(int'(r_sel_index), NUM_MAX) == 1);
   assign w_card    = status[int'(r_cursor)*DIGIT_W +: DIGIT_W];

   assign w_sum       = {1'b0, r_a} + {1'b0, w_card};
   assign w_res_value = DIGIT_W'(w_sum % (DIGIT_W+1)'(MODULUS));
   assign w_zero_pick = (r_a == '0) || (w_card == '0);

   // Only the highest-priority edge survives; everything is dropped during RESULT.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      w_cmd = CMD_NONE;
      if (r_state != RESULT) begin
         if      (w_cancel) w_cmd = CMD_CANCEL;
         else if (w_up)     w_cmd = CMD_UP;
         else if (w_down)   w_cmd = CMD_DOWN;
         else if (w_left)   w_cmd = CMD_LEFT;
         else if (w_right)  w_cmd = CMD_RIGHT;
         else if (w_ok)     w_cmd = CMD_OK;
      end
   end

   always_comb begin
      w_state_nx    = r_state;
      w_rej         = 1'b0;
      w_pick        = 1'b0;
      w_result      = 1'b0;
      w_cursor_zero = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_cmd == CMD_OK) begin
               if (w_card == '0 && w_row == player) begin
                  w_rej = 1'b1;
               end else begin
                  w_pick     = 1'b1;
                  w_state_nx = PICKED;
               end
            end
         end
         PICKED: begin
            if (w_cmd == CMD_CANCEL) begin
               w_state_nx = IDLE;
            end else if (w_cmd == CMD_OK) begin
               if (w_row == w_sel_row) begin
                  w_rej         = 1'b1;
                  w_cursor_zero = 1'b1;
                  w_state_nx    = IDLE;
               end else begin
                  w_result   = 1'b1;
                  w_state_nx = RESULT;
               end
            end
         end
         RESULT: begin
            w_cursor_zero = 1'b1;
            w_state_nx    = IDLE;
         end
         default: w_state_nx = IDLE;
      endcase
   end

   // A column left out of range by a shrinking num is clamped before any move applies.
   always_comb begin
      w_cursor_nx = r_cursor;
      if (w_cursor_zero) begin
         w_cursor_nx = '0;
      end else if (w_col >= w_n) begin
         w_cursor_nx = IDX_W'(idx(int'(w_row), w_n - 1, NUM_MAX));
      end else begin
         case (w_cmd)
            CMD_UP, CMD_DOWN: w_cursor_nx = IDX_W'(idx(int'(!w_row), w_col, NUM_MAX));
            CMD_LEFT:  w_cursor_nx = (w_col == 0) ? IDX_W'(idx(int'(!w_row), w_n - 1, NUM_MAX))
                                                  : r_cursor - IDX_W'(1);
            CMD_RIGHT: w_cursor_nx = (w_col == w_n - 1) ? IDX_W'(idx(int'(!w_row), 0, NUM_MAX))
                                                        : r_cursor + IDX_W'(1);
            default:   w_cursor_nx = r_cursor;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_cursor    <= '0;
         r_sel_index <= '0;
         r_a         <= '0;
         r_res_valid <= 1'b0;
         r_res_value <= '0;
         r_res_dst   <= '0;
         r_res_src   <= '0;
         r_rej       <= 1'b0;
         r_draw1     <= 1'b0;
         r_draw2     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make every flop here load from pre-edge values.
         r_state     <= w_state_nx;
         r_cursor    <= w_cursor_nx;
         r_rej       <= w_rej;
         r_res_valid <= w_result;
         if (w_pick) begin
            r_sel_index <= r_cursor;
            r_a         <= w_card;
         end
         if (w_result) begin
            r_res_value <= w_res_value;
            r_res_dst   <= (w_sel_row == player) ? r_sel_index : r_cursor;
            r_res_src   <= (w_sel_row == player) ? r_cursor : r_sel_index;
         end
         r_draw1 <= (w_result && !player && w_zero_pick) || (r_draw1 && !clr_draw);
         r_draw2 <= (w_result &&  player && w_zero_pick) || (r_draw2 && !clr_draw);
      end
   end

   assign cursor    = r_cursor;
   assign picked    = (r_state == PICKED);
   assign sel_index = r_sel_index;
   assign res_valid = r_res_valid;
   assign res_value = r_res_value;
   assign res_dst   = r_res_dst;
   assign res_src   = r_res_src;
   assign rej       = r_rej;
   assign draw1     = r_draw1;
   assign draw2     = r_draw2;

endmodule

// File: tb/tb_card_pick_adder.sv
// Bench for card_pick_adder: directed scenarios plus random button/num/status traffic
// compared against a transaction-level model of the cursor, picks and draw flags.
`timescale 1ns/1ps
module tb_card_pick_adder;

   localparam int NM  = 5;
   localparam int DW  = 4;
   localparam int MOD = 10;
   localparam int IW  = $clog2(2*NM);
   localparam int NW  = $clog2(NM+1);

   localparam int M_UP = 1, M_DOWN = 2, M_LEFT = 4, M_RIGHT = 8, M_OK = 16, M_CANCEL = 32;
`ifdef CARD_PICK_CANCEL_EN
   localparam bit CANCEL_EN = 1'b1;
`else
   localparam bit CANCEL_EN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst_n, player, clr_draw;
   logic [NW-1:0]     num;
   logic [2*NM*DW-1:0] status;
   logic              btn_up, btn_down, btn_left, btn_right, btn_ok;
`ifdef CARD_PICK_CANCEL_EN
   logic              btn_cancel;
`endif
   logic [IW-1:0]     cursor, sel_index, res_dst, res_src;
   logic [DW-1:0]     res_value;
   logic              picked, res_valid, rej, draw1, draw2;

   always #5 clk = ~clk;

   card_pick_adder dut (
      .clk(clk), .rst_n(rst_n), .player(player), .num(num), .status(status),
      .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
      .btn_ok(btn_ok),
`ifdef CARD_PICK_CANCEL_EN
      .btn_cancel(btn_cancel),
`endif
      .clr_draw(clr_draw), .cursor(cursor), .picked(picked), .sel_index(sel_index),
      .res_valid(res_valid), .res_value(res_value), .res_dst(res_dst), .res_src(res_src),
      .rej(rej), .draw1(draw1), .draw2(draw2)
   );

   // Reference model state
   logic [DW-1:0] vals [2*NM];
   int m_cursor, m_sel, m_a, m_res_value, m_res_dst, m_res_src, m_rej_cnt, m_res_cnt;
   bit m_picked;
   bit m_draw [2];

   int mon_rej = 0, mon_res = 0;
   int n_checks = 0, n_fail = 0;

   always @(negedge clk) begin
      if (rej)       mon_rej <= mon_rej + 1;
      if (res_valid) mon_res <= mon_res + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic int eff_n();
      if (num == 0) return 1;
      if (int'(num) > NM) return NM;
      return int'(num);
   endfunction

   function automatic void model_reset();
      m_cursor = 0; m_sel = 0; m_a = 0; m_picked = 0;
      m_res_value = 0; m_res_dst = 0; m_res_src = 0;
      m_draw[0] = 0; m_draw[1] = 0;
   endfunction

   function automatic void model_press(input int mask, input bit clr);
      int n, row, col, p, b, cmd;
      if (clr) begin m_draw[0] = 0; m_draw[1] = 0; end
      n = eff_n(); row = m_cursor / NM; col = m_cursor % NM;
      if (CANCEL_EN && mask[5]) cmd = 5;
      else if (mask[0]) cmd = 0;
      else if (mask[1]) cmd = 1;
      else if (mask[2]) cmd = 2;
      else if (mask[3]) cmd = 3;
      else if (mask[4]) cmd = 4;
      else cmd = -1;
      case (cmd)
         0, 1: m_cursor = (1 - row) * NM + col;
         2, 3: begin
            // Walk a ring of 2n cards: row0 cols then row1 cols.
            p = row * n + col;
            p = (cmd == 3) ? (p + 1) % (2*n) : (p + 2*n - 1) % (2*n);
            m_cursor = (p / n) * NM + p % n;
         end
         4: begin
            if (!m_picked) begin
               if (vals[m_cursor] == 0 && row == int'(player)) m_rej_cnt++;
               else begin m_picked = 1; m_sel = m_cursor; m_a = vals[m_cursor]; end
            end else if (row == m_sel / NM) begin
               m_rej_cnt++; m_cursor = 0; m_picked = 0;
            end else begin
               b = vals[m_cursor];
               m_res_value = (m_a + b) % MOD;
               if (row == int'(player)) begin m_res_dst = m_cursor; m_res_src = m_sel; end
               else begin m_res_dst = m_sel; m_res_src = m_cursor; end
               m_res_cnt++;
               if (m_a == 0 || b == 0) m_draw[player] = 1;
               m_cursor = 0; m_picked = 0;
            end
         end
         5: m_picked = 0;
         default: ;
      endcase
   endfunction

   task automatic drive_status();
      for (int k = 0; k < 2*NM; k++) status[k*DW +: DW] = vals[k];
   endtask

   task automatic check_all();
      check("cursor",     cursor,    m_cursor);
      check("picked",     picked,    m_picked);
      check("sel_index",  sel_index, m_sel);
      check("res_value",  res_value, m_res_value);
      check("res_dst",    res_dst,   m_res_dst);
      check("res_src",    res_src,   m_res_src);
      check("draw1",      draw1,     m_draw[0]);
      check("draw2",      draw2,     m_draw[1]);
      check("rej_pulses", mon_rej,   m_rej_cnt);
      check("res_pulses", mon_res,   m_res_cnt);
   endtask

   task automatic press(input int mask, input bit clr = 1'b0);
      @(posedge clk); #1;
      btn_up = mask[0]; btn_down = mask[1]; btn_left = mask[2];
      btn_right = mask[3]; btn_ok = mask[4]; clr_draw = clr;
`ifdef CARD_PICK_CANCEL_EN
      btn_cancel = mask[5];
`endif
      @(posedge clk); #1;
      btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_ok = 0; clr_draw = 0;
`ifdef CARD_PICK_CANCEL_EN
      btn_cancel = 0;
`endif
      repeat (3) @(posedge clk); #1;
      model_press(mask, clr);
      check_all();
   endtask

   task automatic set_num(input int v);
      int n;
      num = NW'(v);
      repeat (3) @(posedge clk); #1;
      n = eff_n();
      if (m_cursor % NM >= n) m_cursor = (m_cursor / NM) * NM + n - 1;
      check_all();
   endtask

   task automatic goto_idx(input int target);
      for (int i = 0; i < 2*NM + 1 && m_cursor != target; i++) press(M_RIGHT);
      check("goto", cursor, target);
   endtask

   task automatic set_val(input int k, input int v);
      vals[k] = DW'(v);
      drive_status();
   endtask

   int r, b, mask, saved;

   initial begin
      rst_n = 0; player = 0; num = NW'(5); clr_draw = 0;
      btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_ok = 0;
`ifdef CARD_PICK_CANCEL_EN
      btn_cancel = 0;
`endif
      for (int k = 0; k < 2*NM; k++) vals[k] = DW'(k + 1);
      drive_status();
      model_reset(); m_rej_cnt = 0; m_res_cnt = 0;
      repeat (2) @(posedge clk); #1;
      check_all();
      check("reset_res_valid", res_valid, 0);
      check("reset_rej", rej, 0);
      @(posedge clk); #3 rst_n = 1;

      // Cursor walk and wrap
      repeat (5) press(M_RIGHT);
      check("t1_right_wrap", cursor, 5);
      press(M_UP);    check("t1_up", cursor, 0);
      press(M_LEFT);  check("t1_left_wrap", cursor, 9);

      // num changes and clamp
      set_num(3);     check("t2_clamp3", cursor, 7);
      press(M_UP);    check("t2_up", cursor, 2);
      press(M_RIGHT); check("t2_right_n3", cursor, 5);
      press(M_UP);    check("t2_up_back", cursor, 0);
      set_num(5); goto_idx(4);
      set_num(2);     check("t2_clamp2", cursor, 1);
      set_num(5);

      // Zero-card reject and a plain add
      player = 0;
      press(M_LEFT);
      set_val(0, 0);
      press(M_OK);    check("t3_rej_picked", picked, 0);
      set_val(0, 7);
      press(M_OK);    check("t3_picked", picked, 1);
      set_val(6, 8);
      press(M_DOWN); press(M_RIGHT);
      press(M_OK);
      check("t3_value", res_value, 5);
      check("t3_dst", res_dst, 0);
      check("t3_src", res_src, 6);

      // Player 1 adds a zero from its own row
      player = 1;
      set_val(2, 4); set_val(7, 0);
      goto_idx(2); press(M_OK); press(M_DOWN); press(M_OK);
      check("t4_value", res_value, 4);
      check("t4_dst", res_dst, 7);
      check("t4_src", res_src, 2);
      check("t4_draw2", draw2, 1);
      press(0, 1'b1);
      check("t4_clr", draw2, 0);

      // Same-row second pick and simultaneous edges
      set_val(1, 3);
      goto_idx(1); press(M_OK); goto_idx(3); press(M_OK);
      check("t5_rej_cursor", cursor, 0);
      check("t5_rej_idle", picked, 0);
      press(M_UP | M_LEFT);
      check("t5_up_wins", cursor, 5);

      // Draw set and clear in the same cycle
      set_val(5, 0);
      press(M_UP); press(M_OK); press(M_DOWN);
      press(M_OK, 1'b1);
      check("set_beats_clr", draw2, 1);

`ifdef CARD_PICK_CANCEL_EN
      goto_idx(2); press(M_OK); press(M_RIGHT);
      saved = m_cursor;
      press(M_CANCEL);
      check("cancel_idle", picked, 0);
      check("cancel_cursor", cursor, saved);
`endif

      // Random traffic
      for (int it = 0; it < 400; it++) begin
         r = $urandom_range(0, 99);
         if (r < 25) begin
            press(M_OK, $urandom_range(0, 19) == 0);
         end else if (r < 70) begin
            b = $urandom_range(0, CANCEL_EN ? 5 : 4);
            mask = 1 << b;
            if ($urandom_range(0, 9) == 0) mask = mask | (1 << $urandom_range(0, 4));
            press(mask, $urandom_range(0, 19) == 0);
         end else if (r < 80) begin
            set_num($urandom_range(0, 7));
         end else if (r < 88) begin
            player = 1'($urandom_range(0, 1));
         end else begin
            for (int k = 0; k < 2*NM; k++)
               vals[k] = ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom_range(1, 15));
            drive_status();
         end
      end

      // Reset in the middle of a pick
      for (int k = 0; k < 2*NM; k++) vals[k] = DW'(k + 1);
      drive_status();
      set_num(5);
      if (!m_picked) press(M_OK);
      check("pre_reset_picked", picked, 1);
      @(posedge clk); #3 rst_n = 0; #1;
      model_reset();
      check_all();
      check("async_reset_picked", picked, 0);
      check("async_reset_cursor", cursor, 0);
      @(posedge clk); #3 rst_n = 1;
      press(M_RIGHT);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
